// File: rtl/mnacidpro_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module : mnacidpro_seq_pkg
// Brief  : Shared types and constants for the mnacidpro valve sequencer:
//          FSM states, phase codes, valve maps and the pump step table.
// Rev    : 1.0  initial release
// ============================================================================
package mnacidpro_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_PUMP   = 2'd2,
        ST_DONE   = 2'd3
    } seq_state_t;

    localparam logic [2:0] c_ph_idle    = 3'd0;
    localparam logic [2:0] c_ph_load    = 3'd1;
    localparam logic [2:0] c_ph_lysis   = 3'd2;
    localparam logic [2:0] c_ph_wash    = 3'd3;
    localparam logic [2:0] c_ph_elute   = 3'd4;
    localparam logic [2:0] c_ph_collect = 3'd5;
    localparam logic [2:0] c_ph_done    = 3'd6;

    // Bit positions follow the port order of the valve outputs
    localparam int c_vlv_lysis     = 0;
    localparam int c_vlv_wash      = 1;
    localparam int c_vlv_elute     = 2;
    localparam int c_vlv_dead_end  = 3;
    localparam int c_vlv_vertical  = 4;
    localparam int c_vlv_horiz     = 5;
    localparam int c_vlv_waste     = 6;
    localparam int c_vlv_bead      = 7;
    localparam int c_vlv_loop_exit = 8;
    localparam int c_vlv_bead_trap = 9;
    localparam int c_vlv_collect   = 10;

    localparam logic [10:0] c_map_closed  = 11'h7FF;
    localparam logic [10:0] c_map_load    = ~((11'd1 << c_vlv_bead) | (11'd1 << c_vlv_horiz) |
                                              (11'd1 << c_vlv_bead_trap));
    localparam logic [10:0] c_map_lysis   = ~((11'd1 << c_vlv_lysis) | (11'd1 << c_vlv_vertical) |
                                              (11'd1 << c_vlv_loop_exit));
    localparam logic [10:0] c_map_wash    = ~((11'd1 << c_vlv_wash) | (11'd1 << c_vlv_horiz) |
                                              (11'd1 << c_vlv_waste));
    localparam logic [10:0] c_map_elute   = ~((11'd1 << c_vlv_elute) | (11'd1 << c_vlv_vertical) |
                                              (11'd1 << c_vlv_dead_end));
    localparam logic [10:0] c_map_collect = ~((11'd1 << c_vlv_collect) | (11'd1 << c_vlv_loop_exit));

    function automatic logic [10:0] phase_valves(input logic [2:0] ph);
        case (ph)
            c_ph_load:    return c_map_load;
            c_ph_lysis:   return c_map_lysis;
            c_ph_wash:    return c_map_wash;
            c_ph_elute:   return c_map_elute;
            c_ph_collect: return c_map_collect;
            default:      return c_map_closed;
        endcase
    endfunction

    // Peristaltic step table; reverse mode walks it from the far end
    function automatic logic [2:0] pump_step(input logic [2:0] idx, input logic rev);
        logic [2:0] sel;
        sel = rev ? (3'd5 - idx) : idx;
        case (sel)
            3'd0:    return 3'b110;
            3'd1:    return 3'b100;
            3'd2:    return 3'b101;
            3'd3:    return 3'b001;
            3'd4:    return 3'b011;
            default: return 3'b010;
        endcase
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mnacidpro_pump_phaser.sv
`default_nettype none
// ============================================================================
// Module : mnacidpro_pump_phaser
// Brief  : Pump step divider, 6-step pattern generator and stroke counter.
//          Optional pump_rev input when MNA_SEQ_PUMP_REVERSE_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
module mnacidpro_pump_phaser
    import mnacidpro_seq_pkg::*;
#(
    parameter int PUMP_DIV = 1000,
    parameter int STROKE_W = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                clr,
    input  logic [STROKE_W-1:0] strokes_target,
`ifdef MNA_SEQ_PUMP_REVERSE_EN
    input  logic                pump_rev,
`endif
    output logic [2:0]          pump,
    output logic                stroke_done
);

    localparam int DIV_W = (PUMP_DIV > 1) ? $clog2(PUMP_DIV) : 1;
    localparam logic [DIV_W-1:0] c_div_last = DIV_W'(PUMP_DIV - 1);

    logic [DIV_W-1:0]    r_div;
    logic [2:0]          r_step;
    logic [STROKE_W-1:0] r_stroke;
    logic                r_rev;
    logic                r_active;
    logic [2:0]          r_pump;
    logic                w_rev_req;
    logic                w_step_last;

`ifdef MNA_SEQ_PUMP_REVERSE_EN
    assign w_rev_req = pump_rev;
`else
    assign w_rev_req = 1'b0;
`endif

    assign w_step_last = (r_div == c_div_last);
    // strokes_target is the index of the final stroke
    assign stroke_done = r_active && w_step_last && (r_step == 3'd5) && (r_stroke == strokes_target);
    assign pump        = r_pump;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            r_div    <= '0;
            r_step   <= '0;
            r_stroke <= '0;
            r_rev    <= 1'b0;
            r_active <= 1'b0;
            r_pump   <= 3'b111;
        end else if (en) begin
            if (!r_active) begin
                r_active <= 1'b1;
                r_rev    <= w_rev_req;
                r_pump   <= pump_step(3'd0, w_rev_req);
            end else if (w_step_last) begin
                r_div <= '0;
                if (r_step == 3'd5) begin
                    r_step   <= '0;
                    r_stroke <= r_stroke + 1'b1;
                    r_rev    <= w_rev_req;
                    r_pump   <= pump_step(3'd0, w_rev_req);
                end else begin
                    r_step <= r_step + 3'd1;
                    r_pump <= pump_step(r_step + 3'd1, r_rev);
                end
            end else begin
                r_div <= r_div + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mnacidpro_valve_sequencer.sv
`default_nettype none
// ============================================================================
// Module : mnacidpro_valve_sequencer
// Brief  : Runs LOAD->LYSIS->WASH->ELUTE->COLLECT x SIZE on the mnacidpro chip
//          valves and pump. Optional reverse pumping: MNA_SEQ_PUMP_REVERSE_EN.
// Rev    : 1.0  initial release
// ============================================================================
module mnacidpro_valve_sequencer
    import mnacidpro_seq_pkg::*;
#(
    parameter int SIZE            = 3,
    parameter int PUMP_DIV        = 1000,
    parameter int SETTLE_CYC      = 500,
    parameter int LOAD_STROKES    = 64,
    parameter int LYSIS_STROKES   = 64,
    parameter int WASH_STROKES    = 64,
    parameter int ELUTE_STROKES   = 64,
    parameter int COLLECT_STROKES = 64,
    localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
`ifdef MNA_SEQ_PUMP_REVERSE_EN
    input  logic             pump_rev,
`endif
    output logic             lysis_ctrl,
    output logic             wash_ctrl,
    output logic             elute_ctrl,
    output logic             dead_end_ctrl,
    output logic             vertical_ctrl,
    output logic             horiz_ctrl,
    output logic             waste_ctrl,
    output logic             bead_ctrl,
    output logic             loop_exit_ctrl,
    output logic             bead_trap_ctrl,
    output logic             collect_ctrl,
    output logic [2:0]       pump,
    output logic [IDX_W-1:0] collect_idx,
    output logic [2:0]       phase,
    output logic             busy,
    output logic             done
);

    localparam int MAX_STROKES = max_int(max_int(max_int(LOAD_STROKES, LYSIS_STROKES),
                                                 max_int(WASH_STROKES, ELUTE_STROKES)),
                                         COLLECT_STROKES);
    localparam int STROKE_W = (MAX_STROKES > 1) ? $clog2(MAX_STROKES) : 1;
    localparam int SET_W    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    localparam logic [SET_W-1:0] c_settle_last = SET_W'(SETTLE_CYC - 1);
    localparam logic [IDX_W-1:0] c_idx_last    = IDX_W'(SIZE - 1);

    seq_state_t          r_state;
    logic [2:0]          r_phase;
    logic [IDX_W-1:0]    r_idx;
    logic [SET_W-1:0]    r_settle;
    logic [10:0]         r_valves;
    logic                r_busy;
    logic                r_done;

    seq_state_t          w_nxt_state;
    logic [2:0]          w_nxt_phase;
    logic [IDX_W-1:0]    w_nxt_idx;
    logic [SET_W-1:0]    w_nxt_settle;
    logic [STROKE_W-1:0] w_target;
    logic                w_pump_en;
    logic                w_stroke_done;
    logic [2:0]          w_pump;

    always_comb begin
        case (r_phase)
            c_ph_load:  w_target = STROKE_W'(LOAD_STROKES - 1);
            c_ph_lysis: w_target = STROKE_W'(LYSIS_STROKES - 1);
            c_ph_wash:  w_target = STROKE_W'(WASH_STROKES - 1);
            c_ph_elute: w_target = STROKE_W'(ELUTE_STROKES - 1);
            default:    w_target = STROKE_W'(COLLECT_STROKES - 1);
        endcase
    end

    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_phase  = r_phase;
        w_nxt_idx    = r_idx;
        w_nxt_settle = r_settle;
        if (abort) begin
            w_nxt_state  = ST_IDLE;
            w_nxt_phase  = c_ph_idle;
            w_nxt_idx    = '0;
            w_nxt_settle = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        w_nxt_state  = ST_SETTLE;
                        w_nxt_phase  = c_ph_load;
                        w_nxt_idx    = '0;
                        w_nxt_settle = '0;
                    end
                end
                ST_SETTLE: begin
                    if (r_settle == c_settle_last) begin
                        w_nxt_state  = ST_PUMP;
                        w_nxt_settle = '0;
                    end else begin
                        w_nxt_settle = r_settle + 1'b1;
                    end
                end
                ST_PUMP: begin
                    // COLLECT repeats per outlet before the run completes
                    if (w_stroke_done) begin
                        w_nxt_state = ST_SETTLE;
                        if (r_phase != c_ph_collect) begin
                            w_nxt_phase = r_phase + 3'd1;
                        end else if (r_idx != c_idx_last) begin
                            w_nxt_idx = r_idx + 1'b1;
                        end else begin
                            w_nxt_state = ST_DONE;
                            w_nxt_phase = c_ph_done;
                        end
                    end
                end
                ST_DONE: begin
                    w_nxt_state = ST_IDLE;
                    w_nxt_phase = c_ph_idle;
                    w_nxt_idx   = '0;
                end
                default: begin
                    w_nxt_state = ST_IDLE;
                    w_nxt_phase = c_ph_idle;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_phase  <= c_ph_idle;
            r_idx    <= '0;
            r_settle <= '0;
            r_valves <= c_map_closed;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_nxt_state;
            r_phase  <= w_nxt_phase;
            r_idx    <= w_nxt_idx;
            r_settle <= w_nxt_settle;
            r_valves <= phase_valves(w_nxt_phase);
            r_busy   <= (w_nxt_state == ST_SETTLE) || (w_nxt_state == ST_PUMP);
            r_done   <= (w_nxt_state == ST_DONE);
        end
    end

    // Phaser registers its pump output on the same edge the FSM enters PUMP
    assign w_pump_en = (w_nxt_state == ST_PUMP);

    mnacidpro_pump_phaser #(
        .PUMP_DIV (PUMP_DIV),
        .STROKE_W (STROKE_W)
    ) u_phaser (
        .clk            (clk),
        .rst_n          (rst_n),
        .en             (w_pump_en),
        .clr            (!w_pump_en),
        .strokes_target (w_target),
`ifdef MNA_SEQ_PUMP_REVERSE_EN
        .pump_rev       (pump_rev),
`endif
        .pump           (w_pump),
        .stroke_done    (w_stroke_done)
    );

    assign {collect_ctrl, bead_trap_ctrl, loop_exit_ctrl, bead_ctrl, waste_ctrl, horiz_ctrl,
            vertical_ctrl, dead_end_ctrl, elute_ctrl, wash_ctrl, lysis_ctrl} = r_valves;
    assign pump        = w_pump;
    assign collect_idx = r_idx;
    assign phase       = r_phase;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_mnacidpro_valve_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_mnacidpro_valve_sequencer
// Brief  : Self-checking bench: vector table, corner sequences and random
//          start/abort/reset traffic against a cycle-position reference model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_mnacidpro_valve_sequencer;

    localparam int SIZE       = 3;
    localparam int PUMP_DIV   = 2;
    localparam int SETTLE_CYC = 3;
    localparam int STROKES    = 2;
    localparam int PH_LEN     = SETTLE_CYC + 6 * PUMP_DIV * STROKES;
    localparam int RUN_LEN    = (4 + SIZE) * PH_LEN;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
`ifdef MNA_SEQ_PUMP_REVERSE_EN
    logic pump_rev = 1'b0;
`endif
    logic lysis_ctrl, wash_ctrl, elute_ctrl, dead_end_ctrl, vertical_ctrl, horiz_ctrl;
    logic waste_ctrl, bead_ctrl, loop_exit_ctrl, bead_trap_ctrl, collect_ctrl;
    logic [2:0] pump;
    logic [1:0] collect_idx;
    logic [2:0] phase;
    logic       busy, done;

    typedef struct packed {
        logic [2:0]  ph;
        logic [10:0] valves;
        logic [2:0]  pmp;
        logic        bsy;
        logic        dn;
        logic [1:0]  idx;
    } outs_t;

    typedef struct {
        int    edge_n;
        outs_t exp;
    } vec_t;

    outs_t dut_o;
    assign dut_o = {phase, {collect_ctrl, bead_trap_ctrl, loop_exit_ctrl, bead_ctrl, waste_ctrl,
                    horiz_ctrl, vertical_ctrl, dead_end_ctrl, elute_ctrl, wash_ctrl, lysis_ctrl},
                    pump, busy, done, collect_idx};

    mnacidpro_valve_sequencer #(
        .SIZE(SIZE), .PUMP_DIV(PUMP_DIV), .SETTLE_CYC(SETTLE_CYC),
        .LOAD_STROKES(STROKES), .LYSIS_STROKES(STROKES), .WASH_STROKES(STROKES),
        .ELUTE_STROKES(STROKES), .COLLECT_STROKES(STROKES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
`ifdef MNA_SEQ_PUMP_REVERSE_EN
        .pump_rev(pump_rev),
`endif
        .lysis_ctrl(lysis_ctrl), .wash_ctrl(wash_ctrl), .elute_ctrl(elute_ctrl),
        .dead_end_ctrl(dead_end_ctrl), .vertical_ctrl(vertical_ctrl), .horiz_ctrl(horiz_ctrl),
        .waste_ctrl(waste_ctrl), .bead_ctrl(bead_ctrl), .loop_exit_ctrl(loop_exit_ctrl),
        .bead_trap_ctrl(bead_trap_ctrl), .collect_ctrl(collect_ctrl),
        .pump(pump), .collect_idx(collect_idx), .phase(phase), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks    = 0;
    int failures  = 0;
    int e         = 0;
    int model_t   = 0;
    bit model_rev = 1'b0;
    int done_cnt  = 0;
    vec_t vecs[$];

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    function automatic outs_t mk(logic [2:0] ph, logic [10:0] v, logic [2:0] p,
                                 logic b, logic d, logic [1:0] ix);
        return {ph, v, p, b, d, ix};
    endfunction

    function automatic logic [10:0] map_of(logic [2:0] ph);
        case (ph)
            3'd1:    return 11'h55F;
            3'd2:    return 11'h6EE;
            3'd3:    return 11'h79D;
            3'd4:    return 11'h7E3;
            3'd5:    return 11'h2FF;
            default: return 11'h7FF;
        endcase
    endfunction

    function automatic logic [2:0] pat(int i, bit rev);
        int j;
        j = rev ? 5 - i : i;
        case (j)
            0:       return 3'b110;
            1:       return 3'b100;
            2:       return 3'b101;
            3:       return 3'b001;
            4:       return 3'b011;
            default: return 3'b010;
        endcase
    endfunction

    // Expected outputs from the number of cycles elapsed since start was accepted
    function automatic outs_t model_out(int t, bit rev);
        outs_t o;
        int k, s;
        o = mk(3'd0, 11'h7FF, 3'b111, 1'b0, 1'b0, 2'd0);
        if (t >= 1 && t <= RUN_LEN) begin
            k = (t - 1) / PH_LEN;
            s = (t - 1) % PH_LEN - SETTLE_CYC;
            o.bsy    = 1'b1;
            o.ph     = 3'((k < 4) ? k + 1 : 5);
            o.idx    = 2'((k < 4) ? 0 : k - 4);
            o.valves = map_of(o.ph);
            if (s >= 0) o.pmp = pat((s / PUMP_DIV) % 6, rev);
        end else if (t == RUN_LEN + 1) begin
            o.ph  = 3'd6;
            o.dn  = 1'b1;
            o.idx = 2'(SIZE - 1);
        end
        return o;
    endfunction

    task automatic cmp(string name, outs_t exp);
        checks++;
        if (dut_o !== exp) begin
            failures++;
            $display("FAIL %s edge=%0d actual=%h required=%h", name, e, dut_o, exp);
        end
    endtask

    task automatic step(bit st, bit ab, bit rn);
        start = st;
        abort = ab;
        rst_n = rn;
        @(posedge clk);
        #1;
        e++;
        if (!rn || ab)              model_t = 0;
        else if (model_t == 0)      model_t = st ? 1 : 0;
        else if (model_t > RUN_LEN) model_t = 0;
        else                        model_t++;
        cmp("model", model_out(model_t, model_rev));
    endtask

    task automatic add(int n, outs_t o);
        vec_t v;
        v.edge_n = n;
        v.exp    = o;
        vecs.push_back(v);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog edge=%0d actual=running required=finished", e);
        $fatal(1, "timeout");
    end

    initial begin
        outs_t idle;
        int    d0;
        idle = mk(3'd0, 11'h7FF, 3'b111, 1'b0, 1'b0, 2'd0);

        add(1,   mk(3'd1, 11'h55F, 3'b111, 1'b1, 1'b0, 2'd0));
        add(3,   mk(3'd1, 11'h55F, 3'b111, 1'b1, 1'b0, 2'd0));
        add(4,   mk(3'd1, 11'h55F, 3'b110, 1'b1, 1'b0, 2'd0));
        add(5,   mk(3'd1, 11'h55F, 3'b110, 1'b1, 1'b0, 2'd0));
        add(6,   mk(3'd1, 11'h55F, 3'b100, 1'b1, 1'b0, 2'd0));
        add(8,   mk(3'd1, 11'h55F, 3'b101, 1'b1, 1'b0, 2'd0));
        add(10,  mk(3'd1, 11'h55F, 3'b001, 1'b1, 1'b0, 2'd0));
        add(12,  mk(3'd1, 11'h55F, 3'b011, 1'b1, 1'b0, 2'd0));
        add(14,  mk(3'd1, 11'h55F, 3'b010, 1'b1, 1'b0, 2'd0));
        add(16,  mk(3'd1, 11'h55F, 3'b110, 1'b1, 1'b0, 2'd0));
        add(27,  mk(3'd1, 11'h55F, 3'b010, 1'b1, 1'b0, 2'd0));
        add(28,  mk(3'd2, 11'h6EE, 3'b111, 1'b1, 1'b0, 2'd0));
        add(31,  mk(3'd2, 11'h6EE, 3'b110, 1'b1, 1'b0, 2'd0));
        add(55,  mk(3'd3, 11'h79D, 3'b111, 1'b1, 1'b0, 2'd0));
        add(58,  mk(3'd3, 11'h79D, 3'b110, 1'b1, 1'b0, 2'd0));
        add(82,  mk(3'd4, 11'h7E3, 3'b111, 1'b1, 1'b0, 2'd0));
        add(109, mk(3'd5, 11'h2FF, 3'b111, 1'b1, 1'b0, 2'd0));
        add(136, mk(3'd5, 11'h2FF, 3'b111, 1'b1, 1'b0, 2'd1));
        add(163, mk(3'd5, 11'h2FF, 3'b111, 1'b1, 1'b0, 2'd2));
        add(189, mk(3'd5, 11'h2FF, 3'b010, 1'b1, 1'b0, 2'd2));
        add(190, mk(3'd6, 11'h7FF, 3'b111, 1'b0, 1'b1, 2'd2));
        add(191, mk(3'd0, 11'h7FF, 3'b111, 1'b0, 1'b0, 2'd0));

        step(0, 0, 0);
        step(0, 0, 0);
        cmp("reset", idle);

        // Full protocol run checked at table points
        e  = 0;
        d0 = done_cnt;
        step(1, 0, 1);
        for (int i = 0; i < vecs.size(); i++) begin
            while (e < vecs[i].edge_n) step(0, 0, 1);
            cmp("vec", vecs[i].exp);
        end
        checks++;
        if (done_cnt - d0 != 1) begin
            failures++;
            $display("FAIL done_pulses edge=%0d actual=%0d required=1", e, done_cnt - d0);
        end

        // Abort in WASH, then restart
        e  = 0;
        d0 = done_cnt;
        step(1, 0, 1);
        while (e < 60) step(0, 0, 1);
        step(0, 1, 1);
        cmp("abort_idle", idle);
        while (e < 70) step(0, 0, 1);
        checks++;
        if (done_cnt != d0) begin
            failures++;
            $display("FAIL abort_no_done edge=%0d actual=%0d required=0", e, done_cnt - d0);
        end
        step(1, 0, 1);
        cmp("restart_load", mk(3'd1, 11'h55F, 3'b111, 1'b1, 1'b0, 2'd0));
        while (e < 74) step(0, 0, 1);
        cmp("restart_pump", mk(3'd1, 11'h55F, 3'b110, 1'b1, 1'b0, 2'd0));

        // Abort wins over start
        step(0, 1, 1);
        step(1, 1, 1);
        cmp("abort_over_start", idle);

        // Synchronous reset mid-run
        step(1, 0, 1);
        repeat (40) step(0, 0, 1);
        step(0, 0, 0);
        cmp("rst_midrun", idle);

        // start held high while busy is ignored
        e = 0;
        step(1, 0, 1);
        while (e < 30) step(1, 0, 1);
        cmp("start_ignored", mk(3'd2, 11'h6EE, 3'b111, 1'b1, 1'b0, 2'd0));
        step(0, 1, 1);

`ifdef MNA_SEQ_PUMP_REVERSE_EN
        pump_rev  = 1'b1;
        model_rev = 1'b1;
        e = 0;
        step(1, 0, 1);
        while (e < 4) step(0, 0, 1);
        cmp("rev_first", mk(3'd1, 11'h55F, 3'b010, 1'b1, 1'b0, 2'd0));
        while (e < 28) step(0, 0, 1);
        cmp("rev_phase_len", mk(3'd2, 11'h6EE, 3'b111, 1'b1, 1'b0, 2'd0));
        step(0, 1, 1);
        pump_rev  = 1'b0;
        model_rev = 1'b0;
`endif

        // Random start/abort/reset traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            step((model_t == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 0),
                 $urandom_range(0, 299) == 0,
                 $urandom_range(0, 599) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
